// File: rtl/pe_row_driver_pkg.sv
// Shared types and constants for the PE row driver: FSM states, PE accumulator
// geometry and a nibble-extraction helper.
package pe_row_driver_pkg;

    typedef enum logic [2:0] {
        IDLE,
        CLR,
        FEED,
        FLUSH,
        CAPT,
        OUT
    } state_t;

    localparam int PROD_SHIFT = 10;
    localparam int PE_ACC_W   = 14;
    // Widest nibble vector the helper handles; callers zero-extend to this width.
    localparam int NIB_VEC_W  = 1024;

    function automatic logic [3:0] nib(input logic [NIB_VEC_W-1:0] vec, input int i);
        return vec[4*i +: 4];
    endfunction

endpackage

// File: rtl/pe_row_driver_addr_gen.sv
// Row/beat counters and matrix RAM read address generation for the PE row driver,
// driven by strobes from the FSM in pe_row_driver.
module pe_row_driver_addr_gen #(
    parameter int ROWS   = 64,
    parameter int BEATS  = 16,
    parameter int ADDR_W = $clog2(ROWS*BEATS),
    parameter int ROW_W  = $clog2(ROWS),
    parameter int BEAT_W = $clog2(BEATS)
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              row_clr,
    input  logic              row_inc,
    input  logic              rd_first,
    input  logic              feed,
    output logic [ROW_W-1:0]  row,
    output logic [BEAT_W-1:0] beat,
    output logic              last_row,
    output logic              last_beat,
    output logic              mat_rd_en,
    output logic [ADDR_W-1:0] mat_addr
);

    logic [ADDR_W-1:0] row_base;

    assign last_row  = (row == ROW_W'(ROWS-1));
    assign last_beat = (beat == BEAT_W'(BEATS-1));
    assign row_base  = ADDR_W'(row) * ADDR_W'(BEATS);

    always_ff @(posedge clk) begin
        if (rst) begin
            row <= '0;
        end else if (row_clr) begin
            row <= '0;
        end else if (row_inc) begin
            row <= row + 1'b1;
        end
    end

    // Beat stops at BEATS-1 so FEED can see last_beat; CLR rewinds it.
    always_ff @(posedge clk) begin
        if (rst) begin
            beat <= '0;
        end else if (rd_first) begin
            beat <= '0;
        end else if (feed && !last_beat) begin
            beat <= beat + 1'b1;
        end
    end

    // Reads run one beat ahead of the PE because the RAM has one cycle of latency.
    always_comb begin
        mat_rd_en = 1'b0;
        mat_addr  = '0;
        if (rd_first) begin
            mat_rd_en = 1'b1;
            mat_addr  = row_base;
        end else if (feed && !last_beat) begin
            mat_rd_en = 1'b1;
            mat_addr  = row_base + ADDR_W'(beat) + ADDR_W'(1);
        end
    end

endmodule

// File: rtl/pe_row_driver.sv
// Drives one PE MAC through a full matrix-vector product for the heavy-hash step.
// Build option: define PE_ROW_DRIVER_XOR_EN to XOR each product nibble with the hash.
module pe_row_driver
    import pe_row_driver_pkg::*;
#(
    parameter int WCOUNT  = 4,
    parameter int ROWS    = 64,
    parameter int COLS    = 64,
    parameter int MAT_LAT = 1
) (
    input  logic                                   clk,
    input  logic                                   rst,
    input  logic                                   hash_valid,
    output logic                                   hash_ready,
    input  logic [4*COLS-1:0]                      hash_in,
    output logic                                   mat_rd_en,
    output logic [$clog2(ROWS*COLS/WCOUNT)-1:0]    mat_addr,
    input  logic [4*WCOUNT-1:0]                    mat_data,
    output logic                                   pe_en,
    output logic                                   pe_clr,
    output logic [4*WCOUNT-1:0]                    pe_M,
    output logic [4*WCOUNT-1:0]                    pe_X,
    input  logic [PE_ACC_W-1:0]                    pe_out,
    output logic                                   res_valid,
    input  logic                                   res_ready,
    output logic [4*ROWS-1:0]                      res_data
);

    localparam int BEATS  = COLS / WCOUNT;
    localparam int ADDR_W = $clog2(ROWS*COLS/WCOUNT);
    localparam int ROW_W  = $clog2(ROWS);
    localparam int BEAT_W = $clog2(BEATS);

    // Only a single-cycle RAM and whole beats per row are supported.
    localparam bit unused_cfg_ok = (MAT_LAT == 1) && (COLS % WCOUNT == 0);

    state_t state, state_nxt;

    logic [4*COLS-1:0] hash_reg;
    logic [4*ROWS-1:0] res_reg;
    logic [ROW_W-1:0]  row;
    logic [BEAT_W-1:0] beat;
    logic              last_row, last_beat;
    logic              hash_take, row_clr, row_inc, rd_first, feed, capture;
    logic [3:0]        prod_nib, res_nib;
    logic              unused_pe_low;

    assign unused_pe_low = ^pe_out[PROD_SHIFT-1:0];
    assign prod_nib      = pe_out[PROD_SHIFT+3:PROD_SHIFT];
    assign res_data      = res_reg;

`ifdef PE_ROW_DRIVER_XOR_EN
    assign res_nib = prod_nib ^ nib(NIB_VEC_W'(hash_reg), int'(row));
`else
    assign res_nib = prod_nib;
`endif

    pe_row_driver_addr_gen #(
        .ROWS   (ROWS),
        .BEATS  (BEATS),
        .ADDR_W (ADDR_W),
        .ROW_W  (ROW_W),
        .BEAT_W (BEAT_W)
    ) u_addr_gen (
        .clk       (clk),
        .rst       (rst),
        .row_clr   (row_clr),
        .row_inc   (row_inc),
        .rd_first  (rd_first),
        .feed      (feed),
        .row       (row),
        .beat      (beat),
        .last_row  (last_row),
        .last_beat (last_beat),
        .mat_rd_en (mat_rd_en),
        .mat_addr  (mat_addr)
    );

    always_ff @(posedge clk) begin
        if (rst) begin
            state <= IDLE;
        end else begin
            state <= state_nxt;
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            hash_reg <= '0;
        end else if (hash_take) begin
            hash_reg <= hash_in;
        end
    end

    // Partial results from an aborted run are wiped by reset.
    always_ff @(posedge clk) begin
        if (rst) begin
            res_reg <= '0;
        end else if (capture) begin
            res_reg[int'(row)*4 +: 4] <= res_nib;
        end
    end

    always_comb begin
        state_nxt  = state;
        hash_ready = 1'b0;
        hash_take  = 1'b0;
        row_clr    = 1'b0;
        row_inc    = 1'b0;
        rd_first   = 1'b0;
        feed       = 1'b0;
        capture    = 1'b0;
        pe_en      = 1'b0;
        pe_clr     = 1'b0;
        pe_M       = '0;
        pe_X       = '0;
        res_valid  = 1'b0;
        unique case (state)
            IDLE: begin
                hash_ready = 1'b1;
                if (hash_valid) begin
                    hash_take = 1'b1;
                    row_clr   = 1'b1;
                    state_nxt = CLR;
                end
            end
            CLR: begin
                pe_clr    = 1'b1;
                rd_first  = 1'b1;
                state_nxt = FEED;
            end
            FEED: begin
                pe_en = 1'b1;
                feed  = 1'b1;
                pe_M  = mat_data;
                pe_X  = hash_reg[int'(beat)*(4*WCOUNT) +: 4*WCOUNT];
                if (last_beat) begin
                    state_nxt = FLUSH;
                end
            end
            // Zero operands push the last product through the PE pipeline.
            FLUSH: begin
                pe_en     = 1'b1;
                state_nxt = CAPT;
            end
            CAPT: begin
                capture = 1'b1;
                if (last_row) begin
                    state_nxt = OUT;
                end else begin
                    row_inc   = 1'b1;
                    state_nxt = CLR;
                end
            end
            OUT: begin
                res_valid = 1'b1;
                if (res_ready) begin
                    state_nxt = IDLE;
                end
            end
            default: state_nxt = IDLE;
        endcase
    end

endmodule

// File: tb/tb_pe_row_driver.sv
// Self-checking bench for pe_row_driver with a behavioural PE and a 1-cycle matrix RAM;
// expected results are queued when a hash is sent and compared when the result appears.
module tb_pe_row_driver;

    localparam int WCOUNT  = 4;
    localparam int ROWS    = 64;
    localparam int COLS    = 64;
    localparam int BEATS   = COLS / WCOUNT;
    localparam int ADDR_W  = $clog2(ROWS*BEATS);
    localparam int LATENCY = ROWS*(BEATS+3) + 1;
    localparam int BUDGET  = 3000;

    logic                   clk = 1'b0;
    logic                   rst = 1'b1;
    logic                   hash_valid = 1'b0;
    logic                   hash_ready;
    logic [4*COLS-1:0]      hash_in = '0;
    logic                   mat_rd_en;
    logic [ADDR_W-1:0]      mat_addr;
    logic [4*WCOUNT-1:0]    mat_data = '0;
    logic                   pe_en, pe_clr;
    logic [4*WCOUNT-1:0]    pe_M, pe_X;
    logic [13:0]            pe_out;
    logic                   res_valid;
    logic                   res_ready = 1'b0;
    logic [4*ROWS-1:0]      res_data;

    logic [4*WCOUNT-1:0]    mem [ROWS*BEATS];
    logic [4*ROWS-1:0]      sb [$];
    logic [13:0]            pe_acc = '0;
    logic [9:0]             pe_prod = '0;
    int                     checks = 0;
    int                     errors = 0;
    int                     pcyc = 0;
    int                     hs_cyc = 0;
    int                     clr_count = 0;
    int                     operand_viol = 0;

    pe_row_driver dut (
        .clk        (clk),
        .rst        (rst),
        .hash_valid (hash_valid),
        .hash_ready (hash_ready),
        .hash_in    (hash_in),
        .mat_rd_en  (mat_rd_en),
        .mat_addr   (mat_addr),
        .mat_data   (mat_data),
        .pe_en      (pe_en),
        .pe_clr     (pe_clr),
        .pe_M       (pe_M),
        .pe_X       (pe_X),
        .pe_out     (pe_out),
        .res_valid  (res_valid),
        .res_ready  (res_ready),
        .res_data   (res_data)
    );

    always #5 clk = ~clk;

    always @(posedge clk) pcyc <= pcyc + 1;

    always @(posedge clk) if (mat_rd_en) mat_data <= mem[mat_addr];

    function automatic int dot(input logic [4*WCOUNT-1:0] m, input logic [4*WCOUNT-1:0] x);
        int s = 0;
        for (int i = 0; i < WCOUNT; i++) s += int'(m[4*i +: 4]) * int'(x[4*i +: 4]);
        return s;
    endfunction

    // PE: registered product, accumulator adds the previous product on each enable.
    always @(posedge clk) begin
        if (pe_clr) begin
            pe_acc  <= '0;
            pe_prod <= '0;
        end else if (pe_en) begin
            pe_prod <= 10'(dot(pe_M, pe_X));
            pe_acc  <= pe_acc + 14'(pe_prod);
        end
        if (pe_clr) clr_count <= clr_count + 1;
    end
    assign pe_out = pe_acc;

    always @(negedge clk) begin
        if (!pe_en && (pe_M != '0 || pe_X != '0)) operand_viol <= operand_viol + 1;
    end

    function automatic logic [4*ROWS-1:0] model(input logic [4*COLS-1:0] h);
        logic [4*ROWS-1:0] r = '0;
        for (int row = 0; row < ROWS; row++) begin
            int s = 0;
            logic [3:0] p;
            for (int c = 0; c < COLS; c++) begin
                logic [4*WCOUNT-1:0] w = mem[row*BEATS + c/WCOUNT];
                s += int'(w[(c%WCOUNT)*4 +: 4]) * int'(h[c*4 +: 4]);
            end
            p = 4'((s >> 10) & 15);
`ifdef PE_ROW_DRIVER_XOR_EN
            p = p ^ h[row*4 +: 4];
`endif
            r[row*4 +: 4] = p;
        end
        return r;
    endfunction

    function automatic logic [255:0] rand256();
        logic [255:0] v;
        for (int i = 0; i < 8; i++) v[32*i +: 32] = $urandom;
        return v;
    endfunction

    task automatic fill_matrix(input int mode);
        for (int i = 0; i < ROWS*BEATS; i++) begin
            case (mode)
                0: mem[i] = 16'h0000;
                1: mem[i] = 16'hFFFF;
                2: mem[i] = 16'h8888;
                default: mem[i] = 16'($urandom);
            endcase
        end
    endtask

    task automatic send_hash(input logic [255:0] h, input logic [255:0] exp, output bit ok);
        ok = 1'b0;
        for (int i = 0; i < BUDGET; i++) begin
            @(posedge clk); #1;
            if (hash_ready) begin
                ok = 1'b1;
                break;
            end
        end
        if (!ok) return;
        hash_in    = h;
        hash_valid = 1'b1;
        sb.push_back(exp);
        @(posedge clk); #1;
        hs_cyc     = pcyc;
        hash_valid = 1'b0;
    endtask

    task automatic wait_result(output logic [255:0] data, output int lat, output bit ok);
        ok   = 1'b0;
        data = '0;
        lat  = 0;
        for (int i = 0; i < BUDGET; i++) begin
            if (res_valid) begin
                ok   = 1'b1;
                data = res_data;
                lat  = pcyc - hs_cyc + 1;
                break;
            end
            @(posedge clk); #1;
        end
    endtask

    task automatic test_reset();
        logic [50:0] got, exp;
        rst = 1'b1;
        repeat (3) @(posedge clk);
        #1;
        got = {hash_ready, res_valid, mat_rd_en, pe_en, pe_clr, pe_M, pe_X, mat_addr};
        exp = {1'b1, 4'b0000, 16'h0, 16'h0, 10'h0};
        checks++;
        if (got !== exp) begin
            errors++;
            $display("[TB] FAIL reset_ctrl got %h expected %h", got, exp);
        end
        checks++;
        if (res_data !== '0) begin
            errors++;
            $display("[TB] FAIL reset_res_data got %h expected 0", res_data);
        end
        rst = 1'b0;
    endtask

    task automatic run_pattern(input string name, input int mode, input logic [255:0] h,
                               input logic [255:0] exp_const);
        logic [255:0] got, exp;
        int lat;
        bit ok;
        fill_matrix(mode);
        res_ready = 1'b1;
        send_hash(h, exp_const, ok);
        checks++;
        if (!ok) begin
            errors++;
            $display("[TB] FAIL %s_send hash_ready timeout", name);
            return;
        end
        wait_result(got, lat, ok);
        exp = sb.pop_front();
        checks++;
        if (!ok || got !== exp) begin
            errors++;
            $display("[TB] FAIL %s_result got %h expected %h (valid seen %0d)", name, got, exp, ok);
        end
        checks++;
        if (lat !== LATENCY) begin
            errors++;
            $display("[TB] FAIL %s_latency got %0d expected %0d", name, lat, LATENCY);
        end
        @(posedge clk); #1;
        checks++;
        if (res_valid !== 1'b0 || hash_ready !== 1'b1) begin
            errors++;
            $display("[TB] FAIL %s_idle valid=%b ready=%b expected 0/1", name, res_valid, hash_ready);
        end
    endtask

    task automatic test_all_f();
`ifdef PE_ROW_DRIVER_XOR_EN
        run_pattern("all_f", 1, {64{4'hF}}, {64{4'h1}});
`else
        run_pattern("all_f", 1, {64{4'hF}}, {64{4'hE}});
`endif
    endtask

    task automatic test_all_8();
`ifdef PE_ROW_DRIVER_XOR_EN
        run_pattern("all_8", 2, {64{4'h8}}, {64{4'hC}});
`else
        run_pattern("all_8", 2, {64{4'h8}}, {64{4'h4}});
`endif
    endtask

    task automatic test_zero_matrix();
        logic [255:0] h = {4{64'h0123456789ABCDEF}};
`ifdef PE_ROW_DRIVER_XOR_EN
        run_pattern("zero_mat", 0, h, h);
`else
        run_pattern("zero_mat", 0, h, 256'h0);
`endif
    endtask

    task automatic test_backpressure();
        logic [255:0] h, got, exp;
        int lat;
        bit ok;
        fill_matrix(3);
        h = rand256();
        res_ready = 1'b0;
        send_hash(h, model(h), ok);
        wait_result(got, lat, ok);
        exp = sb.pop_front();
        checks++;
        if (!ok || got !== exp) begin
            errors++;
            $display("[TB] FAIL bp_result got %h expected %h", got, exp);
        end
        for (int i = 0; i < 5; i++) begin
            if (i == 2) begin
                hash_in    = ~h;
                hash_valid = 1'b1;
            end else begin
                hash_valid = 1'b0;
            end
            @(posedge clk); #1;
            checks++;
            if (res_valid !== 1'b1 || hash_ready !== 1'b0 || res_data !== got) begin
                errors++;
                $display("[TB] FAIL bp_hold cycle %0d valid=%b ready=%b data %h expected 1/0 %h",
                         i, res_valid, hash_ready, res_data, got);
            end
        end
        hash_valid = 1'b0;
        res_ready  = 1'b1;
        @(posedge clk); #1;
        checks++;
        if (res_valid !== 1'b0 || hash_ready !== 1'b1) begin
            errors++;
            $display("[TB] FAIL bp_release valid=%b ready=%b expected 0/1", res_valid, hash_ready);
        end
        repeat (3) @(posedge clk);
        #1;
        checks++;
        if (res_valid !== 1'b0 || hash_ready !== 1'b1 || pe_en !== 1'b0 || pe_clr !== 1'b0) begin
            errors++;
            $display("[TB] FAIL ready_no_valid valid=%b ready=%b en=%b clr=%b expected 0/1/0/0",
                     res_valid, hash_ready, pe_en, pe_clr);
        end
    endtask

    task automatic test_reset_mid();
        logic [50:0] st, exp;
        bit ok;
        fill_matrix(1);
        res_ready = 1'b1;
        send_hash({64{4'hF}}, {64{4'hE}}, ok);
        repeat (299) @(posedge clk);
        #1;
        rst = 1'b1;
        @(posedge clk); #1;
        void'(sb.pop_back());
        st  = {hash_ready, res_valid, mat_rd_en, pe_en, pe_clr, pe_M, pe_X, mat_addr};
        exp = {1'b1, 4'b0000, 16'h0, 16'h0, 10'h0};
        checks++;
        if (st !== exp) begin
            errors++;
            $display("[TB] FAIL midrst_ctrl got %h expected %h", st, exp);
        end
        checks++;
        if (res_data !== '0) begin
            errors++;
            $display("[TB] FAIL midrst_res_data got %h expected 0", res_data);
        end
        rst = 1'b0;
`ifdef PE_ROW_DRIVER_XOR_EN
        run_pattern("after_rst", 1, {64{4'hF}}, {64{4'h1}});
`else
        run_pattern("after_rst", 1, {64{4'hF}}, {64{4'hE}});
`endif
    endtask

    task automatic test_back_to_back();
        logic [255:0] h1, h2, got, exp;
        int lat, clr0;
        bit ok;
        fill_matrix(3);
        h1 = rand256();
        h2 = ~h1 ^ rand256();
        if (h2 == h1) h2 = ~h1;
        res_ready = 1'b1;
        clr0 = clr_count;
        for (int k = 0; k < 2; k++) begin
            logic [255:0] h = (k == 0) ? h1 : h2;
            send_hash(h, model(h), ok);
            wait_result(got, lat, ok);
            exp = sb.pop_front();
            checks++;
            if (!ok || got !== exp) begin
                errors++;
                $display("[TB] FAIL b2b_result%0d got %h expected %h", k, got, exp);
            end
            @(posedge clk); #1;
        end
        checks++;
        if (clr_count - clr0 !== 2*ROWS) begin
            errors++;
            $display("[TB] FAIL b2b_clr_count got %0d expected %0d", clr_count - clr0, 2*ROWS);
        end
        checks++;
        if (sb.size() !== 0) begin
            errors++;
            $display("[TB] FAIL scoreboard_left got %0d expected 0", sb.size());
        end
    endtask

    task automatic test_operand_gating();
        checks++;
        if (operand_viol !== 0) begin
            errors++;
            $display("[TB] FAIL operand_gating got %0d nonzero cycles expected 0", operand_viol);
        end
    endtask

    initial begin
        test_reset();
        test_all_f();
        test_all_8();
        test_zero_matrix();
        test_backpressure();
        test_reset_mid();
        test_back_to_back();
        test_operand_gating();
        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
